// File: rtl/instr_fetch_unit_if.sv
// Bus bundle for the instruction fetch unit: burst loader inputs, fetch port
// inputs, and the fetched-word / loader status outputs.
interface instr_fetch_unit_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    // Loader side
    logic              load_start;
    logic [ADDR_W-1:0] load_address;
    logic              load;
    logic              is_instruction;
    logic [DATA_W-1:0] cpu_input;
    logic              load_end;

    // Fetch side
    logic [ADDR_W-1:0] program_counter;
    logic              fetch_req;
    logic              stall;

    // Results and status
    logic [DATA_W-1:0] instruction;
    logic              instr_valid;
    logic              load_busy;
    logic              load_done;
    logic [ADDR_W:0]   load_count;
    logic              load_overflow;

    // Driver of the unit (program loader plus control unit)
    modport master (
        output load_start, load_address, load, is_instruction, cpu_input, load_end,
        output program_counter, fetch_req, stall,
        input  instruction, instr_valid, load_busy, load_done, load_count, load_overflow
    );

    // The instruction fetch unit itself
    modport slave (
        input  load_start, load_address, load, is_instruction, cpu_input, load_end,
        input  program_counter, fetch_req, stall,
        output instruction, instr_valid, load_busy, load_done, load_count, load_overflow
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction store with a burst loader FSM and a registered, stallable
// fetch port. Words are streamed in from a programmed base address; the
// fetch side returns mem[program_counter] one cycle after a request.
module instr_fetch_unit #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_fetch_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   wptr;
    logic [ADDR_W:0]     count;
    logic                overflow;
    logic                restart;
    logic                wr_req;
    logic                wr_en;
    logic [DATA_W-1:0]   mem [DEPTH];

    // Loader state register.
    // NOTE: every clocked block uses non-blocking (<=) assignments so all
    // registers update together from the values seen before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic plus write qualification for the loader.
    // NOTE: every signal driven here is given a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        restart   = 1'b0;
        wr_req    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.load_start) begin
                    state_nxt = LOAD;
                    restart   = 1'b1;
                end
            end
            LOAD: begin
                if (bus.load_start) begin
                    // Restart wins over end; any write strobe in this cycle
                    // belongs to the abandoned burst and is dropped.
                    state_nxt = LOAD;
                    restart   = 1'b1;
                end else begin
                    wr_req = bus.load && bus.is_instruction;
                    if (bus.load_end) state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Only accept a word while there is still room in this burst.
        wr_en = wr_req && (count < DEPTH_CNT);
    end

    // Write pointer, per-burst word count and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (restart) begin
            wptr     <= bus.load_address;
            count    <= '0;
            overflow <= 1'b0;
        end else if (wr_en) begin
            wptr  <= (wptr == LAST_ADDR) ? '0 : wptr + 1'b1;
            count <= count + 1'b1;
        end else if (wr_req) begin
            overflow <= 1'b1;
        end
    end

    // Instruction storage write port.
    // NOTE: the array has no reset so it maps onto plain RAM; contents are
    // undefined until a burst writes them.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr] <= bus.cpu_input;
    end

    // Registered fetch port: loading blocks fetches, stall holds, else fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.instruction <= '0;
            bus.instr_valid <= 1'b0;
        end else if (state == LOAD) begin
            bus.instr_valid <= 1'b0;
        end else if (bus.stall) begin
            bus.instr_valid <= bus.instr_valid;
        end else if (bus.fetch_req) begin
            bus.instruction <= mem[bus.program_counter];
            bus.instr_valid <= 1'b1;
        end else begin
            bus.instr_valid <= 1'b0;
        end
    end

    assign bus.load_busy     = (state == LOAD);
    assign bus.load_done     = (state == DONE);
    assign bus.load_count    = count;
    assign bus.load_overflow = overflow;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit. A behavioural model tracks burst
// status, memory contents and the expected fetch result; a compare process
// checks the DUT against it every cycle, and literal checks pin the model.
module tb_instr_fetch_unit;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    bit   chk_en = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    instr_fetch_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    instr_fetch_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [DATA_W-1:0] mm [DEPTH];
    bit                mk [DEPTH];
    bit                m_busy, m_done, m_ovf;
    int                m_count, m_ptr;
    logic [DATA_W-1:0] e_instr;
    bit                e_valid, e_known;

    initial for (int i = 0; i < DEPTH; i++) mk[i] = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_ovf = 0; m_count = 0; m_ptr = 0;
            e_instr = '0; e_valid = 0; e_known = 1;
        end else begin
            bit was_busy, was_done;
            was_busy = m_busy;
            was_done = m_done;
            // Fetch result is decided by the status before this edge.
            if (was_busy) e_valid = 0;
            else if (bus.stall) begin end
            else if (bus.fetch_req) begin
                e_instr = mm[bus.program_counter];
                e_known = mk[bus.program_counter];
                e_valid = 1;
            end else e_valid = 0;
            // Burst bookkeeping.
            m_done = 0;
            if (bus.load_start && !was_done) begin
                m_busy = 1; m_ptr = int'(bus.load_address); m_count = 0; m_ovf = 0;
            end else if (was_busy) begin
                if (bus.load && bus.is_instruction) begin
                    if (m_count < DEPTH) begin
                        mm[m_ptr] = bus.cpu_input;
                        mk[m_ptr] = 1;
                        m_ptr = (m_ptr + 1) % DEPTH;
                        m_count++;
                    end else m_ovf = 1;
                end
                if (bus.load_end) begin m_busy = 0; m_done = 1; end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every cycle, outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("instr_valid", 32'(bus.instr_valid), 32'(e_valid));
            check("load_busy", 32'(bus.load_busy), 32'(m_busy));
            check("load_done", 32'(bus.load_done), 32'(m_done));
            check("load_count", 32'(bus.load_count), 32'(m_count));
            check("load_overflow", 32'(bus.load_overflow), 32'(m_ovf));
            if (e_known) check("instruction", 32'(bus.instruction), 32'(e_instr));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        bus.load_start = 0; bus.load_address = '0; bus.load = 0; bus.is_instruction = 0;
        bus.cpu_input = '0; bus.load_end = 0; bus.program_counter = '0;
        bus.fetch_req = 0; bus.stall = 0;
    endtask

    task automatic start_burst(input logic [ADDR_W-1:0] base);
        bus.load_start = 1; bus.load_address = base;
        @(negedge clk);
        bus.load_start = 0;
    endtask

    task automatic write_word(input logic [DATA_W-1:0] d, input logic isi);
        bus.load = 1; bus.is_instruction = isi; bus.cpu_input = d;
        @(negedge clk);
        bus.load = 0; bus.is_instruction = 0;
    endtask

    task automatic end_burst();
        bus.load_end = 1;
        @(negedge clk);
        bus.load_end = 0;
    endtask

    task automatic fetch(input logic [ADDR_W-1:0] pc, input logic [DATA_W-1:0] exp);
        bus.fetch_req = 1; bus.program_counter = pc;
        @(negedge clk);
        bus.fetch_req = 0;
        check("fetch_word", 32'(bus.instruction), 32'(exp));
        check("fetch_valid", 32'(bus.instr_valid), 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        #1 rst_n = 0;
        @(negedge clk);
        chk_en = 1;
        rst_n = 1;
        @(negedge clk);

        // Reset mid-burst.
        start_burst(5'd3);
        write_word(8'h11, 1);
        write_word(8'h22, 1);
        check("pre_reset_count", 32'(bus.load_count), 32'd2);
        #2 rst_n = 0;
        #1;
        check("rst_busy", 32'(bus.load_busy), 32'd0);
        check("rst_count", 32'(bus.load_count), 32'd0);
        check("rst_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_instr", 32'(bus.instruction), 32'd0);
        check("rst_ovf", 32'(bus.load_overflow), 32'd0);
        check("rst_done", 32'(bus.load_done), 32'd0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        // Burst load then sequential fetch.
        start_burst(5'd4);
        check("busy_in_load", 32'(bus.load_busy), 32'd1);
        write_word(8'hA1, 1);
        write_word(8'hB2, 1);
        write_word(8'hC3, 1);
        end_burst();
        check("done_pulse", 32'(bus.load_done), 32'd1);
        check("burst_count", 32'(bus.load_count), 32'd3);
        @(negedge clk);
        check("done_drops", 32'(bus.load_done), 32'd0);
        fetch(5'd4, 8'hA1);
        fetch(5'd5, 8'hB2);
        fetch(5'd6, 8'hC3);
        @(negedge clk);
        check("valid_drops", 32'(bus.instr_valid), 32'd0);

        // is_instruction gating: 0xFF is ignored and does not move the pointer.
        start_burst(5'd10);
        write_word(8'hFF, 0);
        check("gated_count", 32'(bus.load_count), 32'd0);
        write_word(8'h5A, 1);
        check("gated_count2", 32'(bus.load_count), 32'd1);
        end_burst();
        @(negedge clk);
        fetch(5'd10, 8'h5A);

        // Stall holds the previous fetch result.
        fetch(5'd4, 8'hA1);
        bus.stall = 1; bus.fetch_req = 1; bus.program_counter = 5'd5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_word", 32'(bus.instruction), 32'hA1);
            check("stall_valid", 32'(bus.instr_valid), 32'd1);
        end
        bus.stall = 0;
        @(negedge clk);
        check("unstall_word", 32'(bus.instruction), 32'hB2);
        bus.fetch_req = 0;
        @(negedge clk);

        // Fetch requested throughout a burst: never valid until after DONE.
        bus.fetch_req = 1; bus.program_counter = 5'd4;
        @(negedge clk);
        start_burst(5'd0);
        write_word(8'h31, 1);
        check("load_fetch_valid", 32'(bus.instr_valid), 32'd0);
        write_word(8'h32, 1);
        check("load_fetch_valid2", 32'(bus.instr_valid), 32'd0);
        end_burst();
        check("done_fetch_valid", 32'(bus.instr_valid), 32'd0);
        @(negedge clk);
        check("post_done_valid", 32'(bus.instr_valid), 32'd1);
        check("post_done_word", 32'(bus.instruction), 32'hA1);
        bus.fetch_req = 0;
        @(negedge clk);

        // Wrap at the top of memory and overflow on the 33rd write.
        start_burst(5'd30);
        for (int i = 0; i < 33; i++) write_word(8'(i + 1), 1);
        check("wrap_count", 32'(bus.load_count), 32'd32);
        check("wrap_ovf", 32'(bus.load_overflow), 32'd1);
        end_burst();
        @(negedge clk);
        check("hold_ovf", 32'(bus.load_overflow), 32'd1);
        fetch(5'd30, 8'h01);
        fetch(5'd31, 8'h02);
        fetch(5'd0, 8'h03);
        fetch(5'd29, 8'h20);

        // A new burst clears count and overflow.
        start_burst(5'd7);
        check("clear_count", 32'(bus.load_count), 32'd0);
        check("clear_ovf", 32'(bus.load_overflow), 32'd0);
        end_burst();
        @(negedge clk);
        @(negedge clk);

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Parametrised instruction store for the simplified CPU, with a burst loader and a registered fetch port. A loader FSM streams instructions from cpu_input into consecutive addresses starting from a programmed base. The fetch side delivers the word at program_counter one cycle after a request, with stall/hold and a valid flag. It replaces the fixed 32x8 combinational instruction store and sits between the program loader and the control unit.

Parameters:
DATA_W, 8, instruction width in bits
ADDR_W, 5, address width
DEPTH, 1<<ADDR_W, number of instruction words; must be ≤ 2^ADDR_W

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
load_start  input  1  begin a burst; latch load_address as the write pointer
load_address  input  ADDR_W  burst base address
load  input  1  write strobe during a burst
is_instruction  input  1  qualifies load; a write occurs only when load && is_instruction
cpu_input  input  DATA_W  word to write
load_end  input  1  terminate the burst
program_counter  input  ADDR_W  fetch address
fetch_req  input  1  request a fetch
stall  input  1  hold the fetch output
instruction  output  DATA_W  registered fetched word
instr_valid  output  1  instruction is fresh for the current request
load_busy  output  1  loader is in LOAD
load_done  output  1  one-cycle pulse at burst end
load_count  output  ADDR_W+1  words written in the current or last burst
load_overflow  output  1  sticky; a write was attempted past DEPTH words

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - instruction=0, instr_valid=0, load_busy=0, load_done=0, load_count=0, load_overflow=0, write pointer=0.
  - Memory contents are not reset and are undefined until written.
- Loader FSM states: IDLE, LOAD, DONE.
  - IDLE: load_start moves to LOAD. On the same edge, wptr<=load_address, load_count<=0, load_overflow<=0.
  - LOAD: load_busy=1. Each cycle with load&&is_instruction:
    - if load_count<DEPTH: mem[wptr]<=cpu_input, wptr<=wptr+1 (wraps modulo DEPTH), load_count+1.
    - otherwise: no write, load_overflow<=1.
  - LOAD: load with is_instruction=0 is ignored.
  - LOAD: load_end moves to DONE. A write in the same cycle as load_end is still performed.
  - LOAD: load_start restarts the burst (re-latch pointer, clear count and overflow). load_start takes priority over load_end.
  - DONE: load_done=1 for exactly one cycle, then IDLE. load_count and load_overflow hold until the next load_start.
  - Writes in IDLE or DONE are ignored.
- Fetch port (1-cycle latency):
  - Priority, highest first: LOAD state, then stall, then fetch_req.
  - LOAD state: instr_valid<=0, instruction holds.
  - stall=1 (not in LOAD): instruction and instr_valid hold.
  - fetch_req=1, stall=0: instruction<=mem[program_counter], instr_valid<=1.
  - fetch_req=0, stall=0: instr_valid<=0, instruction holds.
- Read/write collision: a fetch from the address being written in the same cycle is blocked by the LOAD state, so no bypass is needed.
- load_count widths: saturates at DEPTH and never wraps.

Test Plan:
- Reset mid-burst: load_start base=3, write 2 words, assert rst_n=0 -> all outputs 0, FSM IDLE; after release, a fresh burst works.
- Burst load: load_start base=4, write 0xA1,0xB2,0xC3, load_end -> load_done pulses 1 cycle, load_count=3. Then fetch PC=4,5,6 -> instruction 0xA1,0xB2,0xC3, each one cycle after its request with instr_valid=1.
- Wrap and overflow: DEPTH=32, base=30, 33 writes -> addresses 30,31,0..29 written, load_count=32, load_overflow=1, mem[30] keeps the first word.
- is_instruction gating: in LOAD, load=1 with is_instruction=0 carrying 0xFF -> no write, load_count unchanged, wptr unchanged.
- Stall: fetch PC=4 (0xA1), then stall=1 while PC=5 for 3 cycles -> instruction stays 0xA1 with instr_valid=1. Release stall -> 0xB2 next cycle.
- Fetch during load: fetch_req=1 while load_busy=1 -> instr_valid=0 throughout. Valid data returns the cycle after the first fetch following DONE.
